// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared state encoding and buffer entry layout for the FE fetch controller
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV
`define BP_FE_ENTRY_DECLARE(vaddr_width_mp, instr_width_mp, exc_code_width_mp) \
  typedef struct packed { \
    logic [vaddr_width_mp-1:0] pc; \
    logic [instr_width_mp-1:0] instr; \
    logic exc; \
    logic [exc_code_width_mp-1:0] exc_code; \
  } bp_fe_entry_s
package bp_fe_pkg;
  typedef enum logic [1:0] {
    e_wait = 2'd0,
    e_run  = 2'd1,
    e_halt = 2'd2
  } bp_fe_fetch_state_e;
  localparam int bp_fe_pc_step_lp = 4;
endpackage
`endif

// File: rtl/bp_fe_fetch_fifo.sv
// bp_fe_fetch_fifo: circular-pointer FIFO with registered occupancy and synchronous flush
module bp_fe_fetch_fifo
  import bp_fe_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     enq_v_i,
  input  logic [width_p-1:0]       enq_data_i,
  input  logic                     deq_ready_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [$clog2(els_p):0]   occupancy_o
);
  localparam int ptr_w = $clog2(els_p);
  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0] rptr_r, wptr_r;
  logic deq, full;
  assign v_o = occupancy_o != '0;
  assign full = occupancy_o == ($clog2(els_p) + 1)'(els_p);
  assign deq = v_o & deq_ready_i;
  assign data_o = mem[rptr_r];
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      occupancy_o <= '0;
    end else if (flush_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      occupancy_o <= '0;
    end else begin
      rptr_r <= rptr_r + ptr_w'(deq);
      wptr_r <= wptr_r + ptr_w'(enq_v_i);
      occupancy_o <= occupancy_o + ($clog2(els_p) + 1)'(enq_v_i) - ($clog2(els_p) + 1)'(deq);
    end
  end
  always_ff @(posedge clk_i)
    if (enq_v_i) mem[wptr_r] <= enq_data_i;
  // Upstream credits must make a write into a full buffer impossible unless the head leaves
  assert property (@(posedge clk_i) disable iff (!reset_n_i) enq_v_i & full & ~flush_i |-> deq);
endmodule

// File: rtl/bp_fe_fetch_ctrl_buffered.sv
// bp_fe_fetch_ctrl_buffered: credit-limited sequential fetch with epoch-filtered response buffer
module bp_fe_fetch_ctrl_buffered
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int exc_code_width_p = 3,
  parameter int els_p            = 4,
  parameter int inflight_max_p   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        redirect_v_i,
  input  logic [vaddr_width_p-1:0]    redirect_pc_i,
  output logic                        fetch_v_o,
  output logic [vaddr_width_p-1:0]    fetch_pc_o,
  output logic                        fetch_epoch_o,
  input  logic                        fetch_ready_i,
  input  logic                        resp_v_i,
  input  logic                        resp_epoch_i,
  input  logic [vaddr_width_p-1:0]    resp_pc_i,
  input  logic [instr_width_p-1:0]    resp_instr_i,
  input  logic                        resp_exc_i,
  input  logic [exc_code_width_p-1:0] resp_exc_code_i,
  output logic                        fe_queue_v_o,
  output logic [vaddr_width_p-1:0]    fe_queue_pc_o,
  output logic [instr_width_p-1:0]    fe_queue_instr_o,
  output logic                        fe_queue_exc_o,
  output logic [exc_code_width_p-1:0] fe_queue_exc_code_o,
  input  logic                        fe_queue_ready_i,
  output logic [$clog2(els_p):0]      occupancy_o,
  output logic [1:0]                  state_o
);
  `BP_FE_ENTRY_DECLARE(vaddr_width_p, instr_width_p, exc_code_width_p);
  localparam int if_w = $clog2(inflight_max_p + 1);
  bp_fe_fetch_state_e state_r, state_n;
  logic [vaddr_width_p-1:0] pc_r;
  logic epoch_r;
  logic [if_w-1:0] inflight_r;
  logic fetch_acc, enq_v, head_v;
  bp_fe_entry_s enq_entry, head_raw, head;
  // Buffered entries plus outstanding requests may never exceed the buffer size
  assign fetch_v_o = (state_r == e_run) & ~redirect_v_i
                   & (int'(occupancy_o) + int'(inflight_r) < els_p)
                   & (int'(inflight_r) < inflight_max_p);
  assign fetch_acc = fetch_v_o & fetch_ready_i;
  assign fetch_pc_o = pc_r;
  assign fetch_epoch_o = epoch_r;
  assign enq_v = resp_v_i & (resp_epoch_i == epoch_r) & (state_r != e_halt) & ~redirect_v_i;
  assign enq_entry = '{pc: resp_pc_i, instr: resp_instr_i, exc: resp_exc_i, exc_code: resp_exc_code_i};
  always_comb
    state_n = redirect_v_i ? e_run
            : (state_r == e_run && enq_v && resp_exc_i) ? e_halt
            : state_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_wait;
      pc_r <= '0;
      epoch_r <= 1'b0;
      inflight_r <= '0;
    end else begin
      state_r <= state_n;
      pc_r <= redirect_v_i ? redirect_pc_i : fetch_acc ? pc_r + vaddr_width_p'(bp_fe_pc_step_lp) : pc_r;
      epoch_r <= epoch_r ^ redirect_v_i;
      inflight_r <= inflight_r + if_w'(fetch_acc) - if_w'(resp_v_i);
    end
  end
  bp_fe_fetch_fifo #(.els_p(els_p), .width_p($bits(bp_fe_entry_s))) fifo (
    .clk_i,
    .reset_n_i,
    .flush_i(redirect_v_i),
    .enq_v_i(enq_v),
    .enq_data_i(enq_entry),
    .deq_ready_i(fe_queue_ready_i),
    .v_o(head_v),
    .data_o(head_raw),
    .occupancy_o
  );
  assign head = head_v ? head_raw : '0;
  assign fe_queue_v_o = head_v;
  assign fe_queue_pc_o = head.pc;
  assign fe_queue_instr_o = head.instr;
  assign fe_queue_exc_o = head.exc;
  assign fe_queue_exc_code_o = head.exc_code;
  assign state_o = state_r;
endmodule

// File: tb/tb_bp_fe_fetch_ctrl_buffered.sv
// tb_bp_fe_fetch_ctrl_buffered: randomized bench against a queue-based reference of the fetch controller
module tb_bp_fe_fetch_ctrl_buffered;
  logic clk_i = 0;
  logic reset_n_i = 0;
  logic redirect_v_i = 0;
  logic [38:0] redirect_pc_i = '0;
  logic fetch_v_o, fetch_epoch_o;
  logic [38:0] fetch_pc_o;
  logic fetch_ready_i = 0;
  logic resp_v_i = 0, resp_epoch_i = 0, resp_exc_i = 0;
  logic [38:0] resp_pc_i = '0;
  logic [31:0] resp_instr_i = '0;
  logic [2:0] resp_exc_code_i = '0;
  logic fe_queue_v_o, fe_queue_exc_o;
  logic [38:0] fe_queue_pc_o;
  logic [31:0] fe_queue_instr_o;
  logic [2:0] fe_queue_exc_code_o;
  logic fe_queue_ready_i = 0;
  logic [2:0] occupancy_o;
  logic [1:0] state_o;

  bp_fe_fetch_ctrl_buffered dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
    .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o), .fetch_epoch_o(fetch_epoch_o),
    .fetch_ready_i(fetch_ready_i),
    .resp_v_i(resp_v_i), .resp_epoch_i(resp_epoch_i), .resp_pc_i(resp_pc_i),
    .resp_instr_i(resp_instr_i), .resp_exc_i(resp_exc_i), .resp_exc_code_i(resp_exc_code_i),
    .fe_queue_v_o(fe_queue_v_o), .fe_queue_pc_o(fe_queue_pc_o), .fe_queue_instr_o(fe_queue_instr_o),
    .fe_queue_exc_o(fe_queue_exc_o), .fe_queue_exc_code_o(fe_queue_exc_code_o),
    .fe_queue_ready_i(fe_queue_ready_i),
    .occupancy_o(occupancy_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [38:0] pc;
    logic [31:0] instr;
    logic exc;
    logic [2:0] code;
  } ent_t;
  typedef struct {
    logic [38:0] pc;
    logic ep;
    logic exc;
    logic [2:0] code;
    int due;
  } req_t;

  int checks = 0, failures = 0;
  int cyc = 0, last_due = 0, ndeq = 0;
  int m_state = 0, m_infl = 0;
  logic [38:0] m_pc = '0;
  logic m_epoch = 0;
  ent_t mq[$];
  req_t icq[$];
  logic [38:0] dq_pc[$];
  logic dq_exc[$];
  logic [2:0] dq_code[$];
  logic redir = 0, fr = 0, qr = 0, lat_rand = 0, exc_rand = 0, exc_pc_en = 0;
  logic [38:0] rpc = '0, exc_pc = '0;
  int lat_fix = 1;

  function automatic logic [31:0] ins(input logic [38:0] p);
    return p[31:0] ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_cycle();
    req_t r;
    @(negedge clk_i);
    if (icq.size() > 0 && icq[0].due <= cyc) begin
      r = icq.pop_front();
      resp_v_i = 1; resp_pc_i = r.pc; resp_epoch_i = r.ep; resp_instr_i = ins(r.pc);
      resp_exc_i = r.exc; resp_exc_code_i = r.code;
    end else begin
      resp_v_i = 0; resp_pc_i = '0; resp_epoch_i = 0; resp_instr_i = '0;
      resp_exc_i = 0; resp_exc_code_i = '0;
    end
    redirect_v_i = redir; redirect_pc_i = rpc; fetch_ready_i = fr; fe_queue_ready_i = qr;
    #1;
  endtask

  // Compare against the reference, then advance the reference across the coming edge
  task automatic finish_cycle();
    logic mfv, hv, acc, enq;
    ent_t h, e;
    req_t r;
    int d;
    mfv = (m_state == 1) && !redir && (mq.size() + m_infl < 4) && (m_infl < 2);
    hv = mq.size() > 0;
    h = hv ? mq[0] : '0;
    chk("fetch_v", 64'(fetch_v_o), 64'(mfv));
    chk("fetch_pc", 64'(fetch_pc_o), 64'(m_pc));
    chk("fetch_epoch", 64'(fetch_epoch_o), 64'(m_epoch));
    chk("fq_v", 64'(fe_queue_v_o), 64'(hv));
    chk("fq_pc", 64'(fe_queue_pc_o), 64'(h.pc));
    chk("fq_instr", 64'(fe_queue_instr_o), 64'(h.instr));
    chk("fq_exc", 64'(fe_queue_exc_o), 64'(h.exc));
    chk("fq_code", 64'(fe_queue_exc_code_o), 64'(h.code));
    chk("occupancy", 64'(occupancy_o), 64'(mq.size()));
    chk("state", 64'(state_o), 64'(m_state));
    if (fe_queue_v_o && fe_queue_ready_i) begin
      dq_pc.push_back(fe_queue_pc_o); dq_exc.push_back(fe_queue_exc_o);
      dq_code.push_back(fe_queue_exc_code_o); ndeq++;
    end
    acc = mfv && fr;
    enq = resp_v_i && (resp_epoch_i == m_epoch) && (m_state != 2) && !redir;
    if (acc) begin
      r.pc = m_pc; r.ep = m_epoch;
      r.exc = (exc_pc_en && m_pc == exc_pc) || (exc_rand && $urandom_range(0, 19) == 0);
      r.code = !r.exc ? 3'd0 : (exc_pc_en && m_pc == exc_pc) ? 3'd2 : 3'($urandom_range(0, 7));
      d = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fix);
      if (d <= last_due) d = last_due + 1;
      r.due = d; last_due = d;
      icq.push_back(r);
    end
    if (hv && qr) void'(mq.pop_front());
    if (redir) begin
      mq.delete(); m_pc = rpc; m_epoch = !m_epoch; m_state = 1;
    end else begin
      if (enq) begin
        e.pc = resp_pc_i; e.instr = resp_instr_i; e.exc = resp_exc_i; e.code = resp_exc_code_i;
        mq.push_back(e);
        if (resp_exc_i && m_state == 1) m_state = 2;
      end
      if (acc) m_pc = m_pc + 39'd4;
    end
    m_infl += int'(acc) - int'(resp_v_i);
    cyc++;
  endtask

  task automatic step();
    drive_cycle();
    finish_cycle();
  endtask

  task automatic clear_log();
    dq_pc.delete(); dq_exc.delete(); dq_code.delete(); ndeq = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fetch_v"}, 64'(fetch_v_o), 64'd0);
    chk({tag, "_fetch_pc"}, 64'(fetch_pc_o), 64'd0);
    chk({tag, "_epoch"}, 64'(fetch_epoch_o), 64'd0);
    chk({tag, "_fq_v"}, 64'(fe_queue_v_o), 64'd0);
    chk({tag, "_fq_pc"}, 64'(fe_queue_pc_o), 64'd0);
    chk({tag, "_fq_instr"}, 64'(fe_queue_instr_o), 64'd0);
    chk({tag, "_fq_exc"}, 64'({fe_queue_exc_o, fe_queue_exc_code_o}), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy_o), 64'd0);
    chk({tag, "_state"}, 64'(state_o), 64'd0);
  endtask

  task automatic redirect_to(input logic [38:0] pc);
    redir = 1; rpc = pc;
    step();
    redir = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic found;
    logic [63:0] t;
    int n;
    repeat (3) @(negedge clk_i);
    #1;
    check_reset_outputs("reset");
    reset_n_i = 1;

    // Sequential fetch from 0x8000_0000, response one cycle after acceptance
    fr = 1; qr = 1; lat_fix = 1;
    redir = 1; rpc = 39'h80000000;
    step();
    redir = 0;
    clear_log();
    drive_cycle();
    chk("first_fetch_v", 64'(fetch_v_o), 64'd1);
    chk("first_fetch_pc", 64'(fetch_pc_o), 64'h80000000);
    finish_cycle();
    repeat (4) step();
    chk("first_deq_pc0", 64'(dq_pc.size() > 0 ? dq_pc[0] : '0), 64'h80000000);
    chk("first_deq_pc1", 64'(dq_pc.size() > 1 ? dq_pc[1] : '0), 64'h80000004);
    chk("first_deq_pc2", 64'(dq_pc.size() > 2 ? dq_pc[2] : '0), 64'h80000008);
    ndeq = 0;
    repeat (10) step();
    chk("steady_deq_rate", 64'(ndeq), 64'd10);

    // Backpressure: buffer fills to its depth and fetch stops
    qr = 0;
    repeat (12) step();
    chk("full_occ", 64'(occupancy_o), 64'd4);
    chk("full_fetch_v", 64'(fetch_v_o), 64'd0);

    // Redirect with two requests outstanding
    qr = 1; lat_fix = 2;
    n = 0;
    while (m_infl != 2 && n < 50) begin step(); n++; end
    chk("infl_reached", 64'(m_infl), 64'd2);
    redirect_to(39'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle();
      if (fe_queue_v_o) begin
        chk("redir_first_pc", 64'(fe_queue_pc_o), 64'h100);
        found = 1;
      end
      finish_cycle();
    end
    chk("redir_found", 64'(found), 64'd1);

    // Exception at 0x8000_0008 halts fetch after the preceding entries drain
    lat_fix = 1; exc_pc_en = 1; exc_pc = 39'h80000008;
    redirect_to(39'h80000000);
    clear_log();
    repeat (25) step();
    exc_pc_en = 0;
    chk("exc_ndeq", 64'(dq_pc.size()), 64'd3);
    if (dq_pc.size() == 3) begin
      chk("exc_pc0", 64'(dq_pc[0]), 64'h80000000);
      chk("exc_pc1", 64'(dq_pc[1]), 64'h80000004);
      chk("exc_pc2", 64'(dq_pc[2]), 64'h80000008);
      chk("exc_flags", 64'({dq_exc[0], dq_exc[1], dq_exc[2]}), 64'b001);
      chk("exc_code", 64'(dq_code[2]), 64'd2);
    end
    chk("halt_state", 64'(state_o), 64'd2);
    chk("halt_fetch_v", 64'(fetch_v_o), 64'd0);

    // Redirect and dequeue in the same cycle with three entries buffered
    qr = 0;
    redirect_to(39'h200);
    n = 0;
    while (mq.size() != 3 && n < 30) begin step(); n++; end
    redir = 1; rpc = 39'h300; qr = 1;
    drive_cycle();
    chk("rd_occ_before", 64'(occupancy_o), 64'd3);
    chk("rd_head_v", 64'(fe_queue_v_o), 64'd1);
    finish_cycle();
    redir = 0;
    drive_cycle();
    chk("rd_occ_after", 64'(occupancy_o), 64'd0);
    chk("rd_fetch_pc", 64'(fetch_pc_o), 64'h300);
    chk("rd_fetch_v", 64'(fetch_v_o), 64'd1);
    finish_cycle();

    // PC wraps at the top of the virtual address space
    redirect_to(39'h7F_FFFF_FFFC);
    drive_cycle();
    chk("wrap_pc_top", 64'(fetch_pc_o), 64'h7F_FFFF_FFFC);
    chk("wrap_v", 64'(fetch_v_o), 64'd1);
    finish_cycle();
    drive_cycle();
    chk("wrap_pc_zero", 64'(fetch_pc_o), 64'd0);
    finish_cycle();

    // Randomized traffic
    lat_rand = 1; exc_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      fr = $urandom_range(0, 3) != 0;
      qr = $urandom_range(0, 1) == 1;
      redir = ($urandom_range(0, 49) == 0) || (m_state == 2 && $urandom_range(0, 4) == 0);
      t = {$urandom, $urandom};
      rpc = {t[38:2], 2'b00};
      step();
    end

    // Asynchronous reset in the middle of activity
    @(negedge clk_i);
    #2 reset_n_i = 0;
    #1;
    check_reset_outputs("midreset");
    m_state = 0; m_pc = '0; m_epoch = 0; m_infl = 0; mq.delete(); icq.delete(); last_due = cyc;
    redir = 0; fr = 0; qr = 0;
    redirect_v_i = 0; fetch_ready_i = 0; fe_queue_ready_i = 0; resp_v_i = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1;
    fr = 1; qr = 1;
    redirect_to(39'h40);
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
